mem_bus_fabric: RTL and testbench

Parametrised memory-bus fabric between the Processor memory port and the SoC's ROM, RAM, VRAM and peripheral targets. It supersedes the hard-wired address decode, read mux and colour latch in the SoC top level. Each region is described by a base and mask, a wait-state count and a read-only flag. The block also provides a bank of CPU-writable control registers, stretches accesses with a ready handshake, and latches a fault on illegal writes.

---
 rtl/mem_bus_fabric_pkg.sv | 26 ++
 rtl/mem_bus_fabric_if.sv | 31 +++
 rtl/mem_bus_fabric_wait_counter.sv | 23 ++
 rtl/mem_bus_fabric.sv | 171 +++++++++++++++++
 tb/tb_mem_bus_fabric.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_fabric_pkg.sv
// rtl/mem_bus_fabric_pkg.sv - shared FSM states, SoC memory-map constants and helpers
package mem_bus_fabric_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fab_state_t;

  localparam logic [15:0] MAP_ROM0 = 16'h0000;
  localparam logic [15:0] MAP_ROM1 = 16'h0800;
  localparam logic [15:0] MAP_ROM2 = 16'h1000;
  localparam logic [15:0] MAP_ROM3 = 16'h1800;
  localparam logic [15:0] MAP_VRAM = 16'h4000;
  localparam logic [15:0] MAP_RAM  = 16'hE000;
  localparam logic [15:0] MAP_KBD  = 16'h7F00;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_bus_fabric_if.sv
// rtl/mem_bus_fabric_if.sv - CPU memory port, target strobes and control/fault signals
interface mem_bus_fabric_if #(
  parameter int NUM_REGIONS = 8,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int CTRL_REGS   = 4
);
  logic [ADDR_W-1:0]             memAddr;
  logic [DATA_W-1:0]             memDataWrite;
  logic                          memWrite;
  logic                          memStrobe;
  logic [DATA_W-1:0]             memDataRead;
  logic                          memReady;
  logic [NUM_REGIONS-1:0]        regStrobe;
  logic [NUM_REGIONS-1:0]        regWrite;
  logic [NUM_REGIONS*DATA_W-1:0] regDataRead;
  logic [CTRL_REGS*DATA_W-1:0]   ctrlOut;
  logic                          fault;
  logic [ADDR_W-1:0]             faultAddr;
  logic                          faultClear;

  modport master (
    output memAddr, memDataWrite, memWrite, memStrobe, regDataRead, faultClear,
    input  memDataRead, memReady, regStrobe, regWrite, ctrlOut, fault, faultAddr
  );

  modport slave (
    input  memAddr, memDataWrite, memWrite, memStrobe, regDataRead, faultClear,
    output memDataRead, memReady, regStrobe, regWrite, ctrlOut, fault, faultAddr
  );
endinterface

// File: rtl/mem_bus_fabric_wait_counter.sv
// rtl/mem_bus_fabric_wait_counter.sv - 4-bit loadable down-counter, done on the last wait cycle
module wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_done
);
  logic [3:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_done = (r_count == 4'd1);
endmodule

// File: rtl/mem_bus_fabric.sv
// rtl/mem_bus_fabric.sv - region decode, wait-state stretching, control registers and fault latch
module mem_bus_fabric
  import mem_bus_fabric_pkg::*;
#(
  parameter int                            NUM_REGIONS = 8,
  parameter int                            ADDR_W      = 16,
  parameter int                            DATA_W      = 8,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {8{16'h0000}},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {8{16'hF800}},
  parameter logic [NUM_REGIONS*4-1:0]      REGION_WAIT = {8{4'd0}},
  parameter logic [NUM_REGIONS-1:0]        REGION_RO   = 8'h0F,
  parameter int                            CTRL_REGS   = 4,
  parameter logic [ADDR_W-1:0]             CTRL_BASE   = 16'h6000
) (
  input  logic             clk,
  input  logic             reset,
  mem_bus_fabric_if.slave  bus
);
  localparam int SEL_W = clog2(NUM_REGIONS + 2);
  localparam int CIW   = (CTRL_REGS > 1) ? clog2(CTRL_REGS) : 1;
  localparam logic [SEL_W-1:0] SEL_NONE = SEL_W'(NUM_REGIONS);
  localparam logic [SEL_W-1:0] SEL_CTRL = SEL_W'(NUM_REGIONS + 1);

  fab_state_t r_state, w_state_next;

  logic [SEL_W-1:0]  r_sel;
  logic [CIW-1:0]    r_ctrl_idx;
  logic [DATA_W-1:0] r_ctrl [CTRL_REGS];
  logic              r_fault;
  logic [ADDR_W-1:0] r_fault_addr;

  logic [SEL_W-1:0]  w_sel;
  logic [3:0]        w_sel_wait;
  logic              w_sel_ro;
  logic              w_ctrl_hit;
  logic [CIW-1:0]    w_ctrl_idx;
  logic              w_accept;
  logic              w_load;
  logic              w_dec;
  logic              w_done;
  logic              w_fault_now;
  logic [DATA_W-1:0] w_rdata;

  assign w_ctrl_hit = (bus.memAddr[ADDR_W-1:10] == CTRL_BASE[ADDR_W-1:10]);
  assign w_ctrl_idx = bus.memAddr[CIW-1:0] & CIW'(CTRL_REGS - 1);

  // Control window first, then the lowest-indexed matching region wins.
  always_comb begin
    logic found;
    found      = 1'b0;
    w_sel      = SEL_NONE;
    w_sel_wait = 4'd0;
    w_sel_ro   = 1'b0;
    if (w_ctrl_hit) begin
      w_sel = SEL_CTRL;
    end else begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (!found && ((bus.memAddr & REGION_MASK[i*ADDR_W +: ADDR_W])
                       == REGION_BASE[i*ADDR_W +: ADDR_W])) begin
          found      = 1'b1;
          w_sel      = SEL_W'(i);
          w_sel_wait = REGION_WAIT[i*4 +: 4];
          w_sel_ro   = REGION_RO[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.memStrobe) begin
          w_accept = 1'b1;
          if (w_sel_wait != 4'd0) begin
            w_load       = 1'b1;
            w_state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_dec = 1'b1;
        if (w_done) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  wait_counter u_wait_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_sel_wait),
    .i_dec      (w_dec),
    .o_done     (w_done)
  );

  assign bus.memReady = (r_state == ST_IDLE);

  // Writes into a read-only region never reach the target.
  always_comb begin
    bus.regStrobe = '0;
    bus.regWrite  = '0;
    if (w_accept && !(bus.memWrite && w_sel_ro)) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (w_sel == SEL_W'(i)) begin
          bus.regStrobe[i] = 1'b1;
          bus.regWrite[i]  = bus.memWrite;
        end
      end
    end
  end

  assign w_fault_now = w_accept && bus.memWrite && ((w_sel == SEL_NONE) || w_sel_ro);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sel      <= SEL_NONE;
      r_ctrl_idx <= '0;
      for (int k = 0; k < CTRL_REGS; k++) r_ctrl[k] <= '0;
    end else if (w_accept) begin
      r_sel      <= w_sel;
      r_ctrl_idx <= w_ctrl_idx;
      if (bus.memWrite && (w_sel == SEL_CTRL)) r_ctrl[w_ctrl_idx] <= bus.memDataWrite;
    end
  end

  // A fault arriving with faultClear re-arms the capture, so the new address sticks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_fault_now) begin
      r_fault <= 1'b1;
      if (!r_fault || bus.faultClear) r_fault_addr <= bus.memAddr;
    end else if (bus.faultClear) begin
      r_fault <= 1'b0;
    end
  end

  assign bus.fault     = r_fault;
  assign bus.faultAddr = r_fault_addr;

  always_comb begin
    w_rdata = '0;
    if (r_sel == SEL_CTRL) begin
      w_rdata = r_ctrl[r_ctrl_idx];
    end else begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (r_sel == SEL_W'(i)) w_rdata = bus.regDataRead[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.memDataRead = w_rdata;

  for (genvar g = 0; g < CTRL_REGS; g++) begin : g_ctrl_out
    assign bus.ctrlOut[g*DATA_W +: DATA_W] = r_ctrl[g];
  end
endmodule

// File: tb/tb_mem_bus_fabric.sv
// tb/tb_mem_bus_fabric.sv - directed checks of decode, wait states, control regs and faults
module tb_mem_bus_fabric;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  mem_bus_fabric_if #(.NUM_REGIONS(8), .ADDR_W(16), .DATA_W(8), .CTRL_REGS(4)) bus ();

  mem_bus_fabric #(
    .NUM_REGIONS (8),
    .ADDR_W      (16),
    .DATA_W      (8),
    .REGION_BASE ({16'h0000, 16'h0000, 16'h7F00, 16'h0000, 16'h0000, 16'h7F00, 16'hE000, 16'h0000}),
    .REGION_MASK ({16'hF800, 16'hF800, 16'hFF00, 16'hF800, 16'hF800, 16'hFFF0, 16'hE000, 16'hF800}),
    .REGION_WAIT (32'h0000_0020),
    .REGION_RO   (8'h01),
    .CTRL_REGS   (4),
    .CTRL_BASE   (16'h6000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w);
    bus.memAddr      = a;
    bus.memDataWrite = d;
    bus.memWrite     = w;
    bus.memStrobe    = 1'b1;
    #1;
  endtask

  task automatic idle_bus();
    bus.memStrobe = 1'b0;
    bus.memWrite  = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    reset            = 1'b0;
    bus.memAddr      = '0;
    bus.memDataWrite = '0;
    bus.memWrite     = 1'b0;
    bus.memStrobe    = 1'b0;
    bus.faultClear   = 1'b0;
    bus.regDataRead  = {8'h00, 8'h00, 8'h77, 8'h00, 8'h00, 8'hC3, 8'h5A, 8'hA5};

    tick();
    tick();
    chk("rst_ready",   32'(bus.memReady),    32'h1);
    chk("rst_strobe",  32'(bus.regStrobe),   32'h0);
    chk("rst_write",   32'(bus.regWrite),    32'h0);
    chk("rst_ctrl",    32'(bus.ctrlOut),     32'h0);
    chk("rst_fault",   32'(bus.fault),       32'h0);
    chk("rst_faddr",   32'(bus.faultAddr),   32'h0);
    chk("rst_rdata",   32'(bus.memDataRead), 32'h0);
    reset = 1'b1;
    tick();

    drive(16'h0123, 8'h00, 1'b0);
    chk("rom_strobe", 32'(bus.regStrobe), 32'h01);
    chk("rom_write",  32'(bus.regWrite),  32'h00);
    chk("rom_ready",  32'(bus.memReady),  32'h1);
    tick();
    idle_bus();
    chk("rom_rdata",   32'(bus.memDataRead), 32'hA5);
    chk("rom_ready2",  32'(bus.memReady),    32'h1);
    chk("rom_strobe2", 32'(bus.regStrobe),   32'h00);

    drive(16'h0123, 8'h00, 1'b0);
    tick();
    drive(16'h7F03, 8'h00, 1'b0);
    chk("b2b_strobe", 32'(bus.regStrobe), 32'h04);
    chk("b2b_ready",  32'(bus.memReady),  32'h1);
    tick();
    idle_bus();
    chk("b2b_rdata", 32'(bus.memDataRead), 32'hC3);

    drive(16'hE010, 8'h3C, 1'b1);
    chk("ram_strobe", 32'(bus.regStrobe), 32'h02);
    chk("ram_write",  32'(bus.regWrite),  32'h02);
    tick();
    chk("ram_wait1_ready",  32'(bus.memReady),  32'h0);
    chk("ram_wait1_strobe", 32'(bus.regStrobe), 32'h00);
    tick();
    chk("ram_wait2_ready",  32'(bus.memReady),  32'h0);
    chk("ram_wait2_strobe", 32'(bus.regStrobe), 32'h00);
    idle_bus();
    tick();
    chk("ram_done_ready", 32'(bus.memReady),    32'h1);
    chk("ram_done_rdata", 32'(bus.memDataRead), 32'h5A);
    chk("ram_no_fault",   32'(bus.fault),       32'h0);

    drive(16'h6001, 8'h70, 1'b1);
    chk("ctrl_no_strobe", 32'(bus.regStrobe), 32'h00);
    tick();
    idle_bus();
    chk("ctrl_out", bus.ctrlOut, 32'h0000_7000);
    drive(16'h6001, 8'h00, 1'b0);
    tick();
    idle_bus();
    chk("ctrl_read", 32'(bus.memDataRead), 32'h70);
    drive(16'h6005, 8'h00, 1'b0);
    tick();
    idle_bus();
    chk("ctrl_alias", 32'(bus.memDataRead), 32'h70);
    drive(16'h6402, 8'h00, 1'b0);
    tick();
    idle_bus();
    chk("miss_rdata", 32'(bus.memDataRead), 32'h00);
    chk("miss_read_no_fault", 32'(bus.fault), 32'h0);

    drive(16'h0005, 8'hFF, 1'b1);
    chk("ro_strobe", 32'(bus.regStrobe), 32'h00);
    chk("ro_write",  32'(bus.regWrite),  32'h00);
    tick();
    idle_bus();
    chk("ro_fault", 32'(bus.fault),     32'h1);
    chk("ro_faddr", 32'(bus.faultAddr), 32'h0005);
    drive(16'h9000, 8'h11, 1'b1);
    tick();
    idle_bus();
    chk("second_fault",  32'(bus.fault),     32'h1);
    chk("second_faddr",  32'(bus.faultAddr), 32'h0005);
    drive(16'h9000, 8'h22, 1'b1);
    bus.faultClear = 1'b1;
    tick();
    idle_bus();
    bus.faultClear = 1'b0;
    chk("clr_fault_wins", 32'(bus.fault),     32'h1);
    chk("clr_faddr_new",  32'(bus.faultAddr), 32'h9000);
    bus.faultClear = 1'b1;
    tick();
    bus.faultClear = 1'b0;
    chk("clr_fault", 32'(bus.fault), 32'h0);

    drive(16'h7F03, 8'h00, 1'b0);
    chk("overlap_strobe", 32'(bus.regStrobe), 32'h04);
    tick();
    idle_bus();
    chk("overlap_rdata", 32'(bus.memDataRead), 32'hC3);

    drive(16'h0007, 8'h01, 1'b1);
    tick();
    drive(16'hE000, 8'h00, 1'b0);
    chk("pre_rst_fault", 32'(bus.fault), 32'h1);
    tick();
    idle_bus();
    chk("mid_wait_ready", 32'(bus.memReady), 32'h0);
    reset = 1'b0;
    tick();
    chk("rst_wait_ready", 32'(bus.memReady),    32'h1);
    chk("rst_wait_ctrl",  bus.ctrlOut,          32'h0);
    chk("rst_wait_fault", 32'(bus.fault),       32'h0);
    chk("rst_wait_rdata", 32'(bus.memDataRead), 32'h0);
    reset = 1'b1;
    tick();
    chk("post_rst_ready", 32'(bus.memReady), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
